// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin issue stage with an optional lock, sharing one ALU
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter logic [3:0] IDLE_OP = 4'hF,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic req0_ready,
  output logic req1_ready,
  input  logic [3:0] req0_op,
  input  logic [3:0] req1_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_b,
  input  logic req0_lock,
  input  logic req1_lock,
  output logic rsp0_valid,
  output logic rsp1_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [2:0] rsp_flags,
  output logic [3:0] alu_opcode,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [2:0] alu_flags,
  output logic [1:0] lock_owner
);
  logic lg, id, issue_v, g0, g1, acc, lk, own_v, expire;
  logic [7:0] tcnt, tcnt_nxt;
  logic [1:0] lock_nxt;
  assign g0 = rst_n && req0_valid && (lock_owner == 2'b01 || (lock_owner == 2'b00 && (!req1_valid || lg)));
  assign g1 = rst_n && req1_valid && (lock_owner == 2'b10 || (lock_owner == 2'b00 && (!req0_valid || !lg)));
  assign acc = g0 | g1;
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign rsp_flags = alu_flags;
  always_comb begin
    lk = g1 ? req1_lock : req0_lock;
    own_v = lock_owner[1] ? req1_valid : req0_valid;
    expire = lock_owner != 2'b00 && !own_v && tcnt == 8'(LOCK_TIMEOUT - 1);
    lock_nxt = acc ? (lk ? {g1, g0} : 2'b00) : expire ? 2'b00 : lock_owner;
    tcnt_nxt = (lock_owner == 2'b00 || own_v || expire) ? 8'd0 : tcnt + 8'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lg <= 1'b1;
      lock_owner <= 2'b00;
      tcnt <= 8'd0;
      alu_opcode <= IDLE_OP;
      alu_in1 <= '0;
      alu_in2 <= '0;
      id <= 1'b0;
      issue_v <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data <= '0;
      rsp1_data <= '0;
    end else begin
      lg <= acc ? g1 : lg;
      lock_owner <= lock_nxt;
      tcnt <= tcnt_nxt;
      alu_opcode <= acc ? (g1 ? req1_op : req0_op) : IDLE_OP;
      alu_in1 <= acc ? (g1 ? req1_a : req0_a) : '0;
      alu_in2 <= acc ? (g1 ? req1_b : req0_b) : '0;
      id <= acc ? g1 : id;
      issue_v <= acc;
      rsp0_valid <= issue_v && !id;
      rsp1_valid <= issue_v && id;
      rsp0_data <= (issue_v && !id) ? alu_result : rsp0_data;
      rsp1_data <= (issue_v && id) ? alu_result : rsp1_data;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with a response scoreboard for alu_arbiter
module tb_alu_arbiter;
  typedef struct packed {logic p; logic [15:0] d; logic [2:0] f;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid, req1_valid, req0_ready, req1_ready, req0_lock, req1_lock;
  logic [3:0] req0_op, req1_op, alu_opcode;
  logic [15:0] req0_a, req1_a, req0_b, req1_b, rsp0_data, rsp1_data, alu_in1, alu_in2, alu_result;
  logic rsp0_valid, rsp1_valid, alu_v;
  logic [2:0] rsp_flags, alu_flags = 3'b000;
  logic [1:0] lock_owner;
  int checks = 0, failures = 0;
  exp_t sb[$];
  exp_t e0, e1, m;
  always #5 clk = ~clk;
  alu_arbiter #(.LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_lock(req0_lock), .req1_lock(req1_lock),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_data(rsp0_data), .rsp1_data(rsp1_data), .rsp_flags(rsp_flags),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_flags(alu_flags), .lock_owner(lock_owner)
  );
  always_comb begin
    alu_result = alu_opcode == 4'h0 ? alu_in1 + alu_in2 : alu_opcode == 4'h1 ? alu_in1 - alu_in2 :
                 alu_opcode == 4'h2 ? alu_in1 ^ alu_in2 : 16'h0000;
    alu_v = alu_opcode == 4'h0 ? (alu_in1[15] == alu_in2[15] && alu_result[15] != alu_in1[15]) :
            alu_opcode == 4'h1 ? (alu_in1[15] != alu_in2[15] && alu_result[15] != alu_in1[15]) : 1'b0;
  end
  always @(posedge clk) if (alu_opcode <= 4'h2) alu_flags <= {alu_result == 16'h0000, alu_v, alu_result[15]};
  function automatic void chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endfunction
  always @(negedge clk) if (rst_n) begin
    if (req0_valid && req0_ready) sb.push_back(e0);
    if (req1_valid && req1_ready) sb.push_back(e1);
  end
  always @(negedge clk) if (rst_n && (rsp0_valid || rsp1_valid)) begin
    chk("rsp_one_hot", {15'd0, rsp0_valid & rsp1_valid}, 16'd0);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_unexpected actual=%b%b required=00", rsp1_valid, rsp0_valid);
    end else begin
      m = sb.pop_front();
      chk("rsp_port", {15'd0, rsp1_valid}, {15'd0, m.p});
      chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, m.d);
      chk("rsp_flags", {13'd0, rsp_flags}, {13'd0, m.f});
    end
  end
  task automatic drv(input logic p, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic lk, input logic [15:0] d, input logic [2:0] f);
    if (!p) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_lock = lk; e0 = '{1'b0, d, f};
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_lock = lk; e1 = '{1'b1, d, f};
    end
  endtask
  task automatic idle(input logic p);
    if (!p) begin req0_valid = 1'b0; req0_lock = 1'b0; end
    else begin req1_valid = 1'b0; req1_lock = 1'b0; end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic rdy(input logic r0, input logic r1, input logic [1:0] lo);
    #1;
    chk("ready0", {15'd0, req0_ready}, {15'd0, r0});
    chk("ready1", {15'd0, req1_ready}, {15'd0, r1});
    chk("lock_owner", {14'd0, lock_owner}, {14'd0, lo});
  endtask
  task automatic rst_vals();
    chk("rst_opcode", {12'd0, alu_opcode}, 16'h000F);
    chk("rst_in1", alu_in1, 16'h0000);
    chk("rst_in2", alu_in2, 16'h0000);
    chk("rst_rsp_valid", {14'd0, rsp1_valid, rsp0_valid}, 16'h0000);
    chk("rst_rsp0_data", rsp0_data, 16'h0000);
    chk("rst_rsp1_data", rsp1_data, 16'h0000);
    chk("rst_lock_owner", {14'd0, lock_owner}, 16'h0000);
    chk("rst_ready", {14'd0, req1_ready, req0_ready}, 16'h0000);
  endtask
  initial begin
    {req0_op, req1_op, req0_a, req1_a, req0_b, req1_b, req0_lock, req1_lock} = '0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_vals();
    idle(0);
    idle(1);
    rst_n = 1'b1;
    cyc(); drv(0, 4'h0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 3'b000); rdy(1, 0, 2'b00);
    cyc(); idle(0);
    chk("alu_opcode_t1", {12'd0, alu_opcode}, 16'h0000);
    chk("alu_in1_t1", alu_in1, 16'h0003);
    chk("alu_in2_t1", alu_in2, 16'h0004);
    cyc();
    chk("rsp0_valid_t2", {15'd0, rsp0_valid}, 16'h0001);
    chk("rsp0_data_t2", rsp0_data, 16'h0007);
    chk("rsp1_valid_t2", {15'd0, rsp1_valid}, 16'h0000);
    repeat (2) cyc();
    rst_n = 1'b0; sb.delete(); repeat (2) cyc(); rst_n = 1'b1;
    cyc(); drv(0, 4'h0, 16'h1000, 16'h0234, 1'b0, 16'h1234, 3'b000);
    drv(1, 4'h1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 3'b100); rdy(1, 0, 2'b00);
    cyc(); drv(0, 4'h2, 16'h00FF, 16'h0F0F, 1'b0, 16'h0FF0, 3'b000); rdy(0, 1, 2'b00);
    cyc(); drv(1, 4'h0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 3'b011); rdy(1, 0, 2'b00);
    cyc(); rdy(0, 1, 2'b00);
    cyc(); idle(0); idle(1);
    repeat (3) cyc();
    cyc(); drv(0, 4'h1, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 3'b001); rdy(1, 0, 2'b00);
    cyc(); idle(0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_opcode", {12'd0, alu_opcode}, 16'h000F);
      chk("idle_flags", {13'd0, alu_flags}, 16'h0001);
    end
    cyc(); drv(1, 4'h0, 16'h0010, 16'h0001, 1'b1, 16'h0011, 3'b000); rdy(0, 1, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      cyc(); drv(0, 4'h1, 16'h0009, 16'h0003, 1'b0, 16'h0006, 3'b000);
      drv(1, 4'h0, 16'(k * 256), 16'h0001, 1'b1, 16'(k * 256 + 1), 3'b000); rdy(0, 1, 2'b10);
    end
    cyc(); drv(1, 4'h0, 16'h0400, 16'h0001, 1'b0, 16'h0401, 3'b000); rdy(0, 1, 2'b10);
    cyc(); idle(1); rdy(1, 0, 2'b00);
    cyc(); idle(0);
    repeat (3) cyc();
    cyc(); drv(0, 4'h0, 16'h0002, 16'h0003, 1'b1, 16'h0005, 3'b000); rdy(1, 0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 0) begin idle(0); drv(1, 4'h0, 16'h0006, 16'h0007, 1'b0, 16'h000D, 3'b000); end
      rdy(0, 0, 2'b01);
    end
    cyc(); rdy(0, 1, 2'b00);
    cyc(); idle(1);
    repeat (3) cyc();
    cyc(); drv(0, 4'h0, 16'h1111, 16'h1111, 1'b0, 16'h2222, 3'b000); rdy(1, 0, 2'b00);
    cyc(); idle(0); rst_n = 1'b0; sb.delete();
    #1;
    rst_vals();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    drv(0, 4'h0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b000);
    drv(1, 4'h0, 16'h0008, 16'h0008, 1'b0, 16'h0010, 3'b000); rdy(1, 0, 2'b00);
    cyc(); idle(0); rdy(0, 1, 2'b00);
    cyc(); idle(1);
    repeat (4) cyc();
    chk("sb_drained", 16'(sb.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
